// File: rtl/demux_1to16_deser_pkg.sv
// Shared frame geometry for the 1-to-16 serial demux and its decoders.
package demux_1to16_deser_pkg;

    localparam int FRAME_BITS = 16;
    localparam int GROUP_W    = 4;
    localparam int NUM_GROUPS = 4;
    localparam int SEL_W      = 4;

endpackage

// File: rtl/demux_1to16_deser_if.sv
// Serial-in / frame-out bundle of the 1-to-16 demux; slave is the demux side.
interface demux_1to16_deser_if;
    import demux_1to16_deser_pkg::*;

    logic               in_bit;
    logic               in_valid;
    logic               in_ready;
    logic               sync;
    logic [SEL_W-1:0]   sel_cnt;
    logic [GROUP_W-1:0] a;
    logic [GROUP_W-1:0] b;
    logic [GROUP_W-1:0] c;
    logic [GROUP_W-1:0] d;
    logic               out_valid;
    logic               out_ready;
    logic               parity_err;

    modport master (
        output in_bit, in_valid, sync, out_ready,
        input  in_ready, sel_cnt, a, b, c, d, out_valid, parity_err
    );

    modport slave (
        input  in_bit, in_valid, sync, out_ready,
        output in_ready, sel_cnt, a, b, c, d, out_valid, parity_err
    );

endinterface

// File: rtl/demux_1to16_deser_demux_1to4_en.sv
// 2-bit select with enable to one-hot 4-bit decoder; building block of the slot write enables.
module demux_1to4_en
    import demux_1to16_deser_pkg::*;
(
    input  logic [1:0]         sel,
    input  logic               en,
    output logic [GROUP_W-1:0] y
);

    always_comb begin
        y      = '0;
        y[sel] = en;
    end

endmodule

// File: rtl/demux_1to16_deser.sv
// Serial-to-parallel 1-to-16 demux with valid/ready frame output.
// Build option DEMUX_PARITY_EN: adds a 17th even-parity beat per frame and drives parity_err.
module demux_1to16_deser
    import demux_1to16_deser_pkg::*;
#(
    parameter bit DESCEND = 1'b0
) (
    input logic                clk,
    input logic                rst,
    demux_1to16_deser_if.slave bus
);

`ifdef DEMUX_PARITY_EN
    localparam int               CNT_W = SEL_W + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_BITS);
`else
    localparam int               CNT_W = SEL_W;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(FRAME_BITS - 1);
`endif

    logic [CNT_W-1:0]      cnt;
    logic [FRAME_BITS-1:0] cap;
    logic [FRAME_BITS-1:0] cap_wr;
    logic [FRAME_BITS-1:0] wen;
    logic [FRAME_BITS-1:0] frame_q;
    logic [SEL_W-1:0]      slot;
    logic [SEL_W-1:0]      idx;
    logic [NUM_GROUPS-1:0] grp_en;
    logic                  accept;
    logic                  is_last;
    logic                  data_we;
    logic                  out_valid_q;

    assign is_last      = (cnt == LAST);
    assign bus.in_ready = !is_last || !out_valid_q || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;

    // A beat taken together with sync always lands in slot 0; 15-k equals ~k on 4 bits.
    assign slot = bus.sync ? '0 : cnt[SEL_W-1:0];
    assign idx  = DESCEND ? ~slot : slot;

`ifdef DEMUX_PARITY_EN
    assign data_we = accept && (bus.sync || !is_last);
`else
    assign data_we = accept;
`endif

    demux_1to4_en u_grp (
        .sel (idx[3:2]),
        .en  (data_we),
        .y   (grp_en)
    );

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_bit
        demux_1to4_en u_bit (
            .sel (idx[1:0]),
            .en  (grp_en[g]),
            .y   (wen[g*GROUP_W +: GROUP_W])
        );
    end

    // Capture with the current beat merged in; sync drops the partial frame first.
    assign cap_wr = ((bus.sync ? '0 : cap) & ~wen) | (wen & {FRAME_BITS{bus.in_bit}});

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            cap         <= '0;
            frame_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (bus.sync) begin
                cnt <= accept ? CNT_W'(1) : '0;
                cap <= cap_wr;
            end else if (accept) begin
                if (is_last) begin
                    cnt         <= '0;
                    cap         <= '0;
                    frame_q     <= cap_wr;
                    out_valid_q <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                    cap <= cap_wr;
                end
            end
        end
    end

`ifdef DEMUX_PARITY_EN
    logic perr_q;

    // Parity beat is the final one, so cap already holds all 16 data bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else if (accept && !bus.sync && is_last) begin
            perr_q <= (^cap) ^ bus.in_bit;
        end
    end

    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.sel_cnt   = cnt[SEL_W-1:0];
    assign bus.out_valid = out_valid_q;
    assign bus.a         = frame_q[0*GROUP_W +: GROUP_W];
    assign bus.b         = frame_q[1*GROUP_W +: GROUP_W];
    assign bus.c         = frame_q[2*GROUP_W +: GROUP_W];
    assign bus.d         = frame_q[3*GROUP_W +: GROUP_W];

endmodule

// File: tb/tb_demux_1to16_deser.sv
// Scoreboard bench for demux_1to16_deser: ascending and descending instances share one stimulus stream.
module tb_demux_1to16_deser;

    typedef struct {
        logic [15:0] asc;
        logic [15:0] desc;
        logic        perr;
    } exp_t;

`ifdef DEMUX_PARITY_EN
    localparam int M_LAST = 16;
`else
    localparam int M_LAST = 15;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_cnt   = 0;
    logic [15:0] m_bits = '0;
    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    demux_1to16_deser_if bus ();
    demux_1to16_deser_if bus2 ();

    assign bus2.in_bit    = bus.in_bit;
    assign bus2.in_valid  = bus.in_valid;
    assign bus2.sync      = bus.sync;
    assign bus2.out_ready = bus.out_ready;

    demux_1to16_deser #(.DESCEND(1'b0)) dut_asc (.clk(clk), .rst(rst), .bus(bus));
    demux_1to16_deser #(.DESCEND(1'b1)) dut_desc (.clk(clk), .rst(rst), .bus(bus2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] reverse16(input logic [15:0] v);
        logic [15:0] r;
        for (int k = 0; k < 16; k++) r[15-k] = v[k];
        return r;
    endfunction

    // Reference slot model: updated whenever the bench knows a beat is taken.
    task automatic model_accept(input logic bitv, input logic s);
        exp_t e;
        if (s) begin
            m_cnt  = 0;
            m_bits = '0;
        end
        if (m_cnt == M_LAST) begin
            e.asc = m_bits;
`ifdef DEMUX_PARITY_EN
            e.perr = (^m_bits) ^ bitv;
`else
            e.asc[15] = bitv;
            e.perr    = 1'b0;
`endif
            e.desc = reverse16(e.asc);
            exp_q.push_back(e);
            m_cnt  = 0;
            m_bits = '0;
        end else begin
            m_bits[m_cnt] = bitv;
            m_cnt++;
        end
    endtask

    task automatic drive_beat(input logic bitv, input logic s);
        int guard = 0;
        bus.in_bit   = bitv;
        bus.in_valid = 1'b1;
        bus.sync     = s;
        @(negedge clk);
        check("sel_cnt", 32'(bus.sel_cnt), 32'(m_cnt[3:0]));
        if (!bus.in_ready) check("stall_slot", m_cnt, M_LAST);
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.in_ready) begin
            check("stall_timeout", 32'(bus.in_ready), 1);
        end else begin
            model_accept(bitv, s);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.sync     = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_frame(input logic [15:0] v, input bit gaps, input logic pflip, input logic s0);
        for (int k = 0; k < 16; k++) begin
            if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
            drive_beat(v[k], (k == 0) ? s0 : 1'b0);
        end
`ifdef DEMUX_PARITY_EN
        if (gaps && $urandom_range(0, 1) == 1) idle(1);
        drive_beat((^v) ^ pflip, 1'b0);
`else
        if (pflip) idle(0);
`endif
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.sync     = 1'b0;
        rst          = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
        m_cnt  = 0;
        m_bits = '0;
        exp_q.delete();
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_abcd", 32'({bus.d, bus.c, bus.b, bus.a}), 0);
        check("rst_sel_cnt", 32'(bus.sel_cnt), 0);
        check("rst_parity_err", 32'(bus.parity_err), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_desc_valid", 32'(bus2.out_valid), 0);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("drain_pending", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_frame", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                check("frame_asc", 32'({bus.d, bus.c, bus.b, bus.a}), 32'(mon_e.asc));
                check("frame_desc_valid", 32'(bus2.out_valid), 1);
                check("frame_desc", 32'({bus2.d, bus2.c, bus2.b, bus2.a}), 32'(mon_e.desc));
                check("parity_err", 32'(bus.parity_err), 32'(mon_e.perr));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic final_bit;
        rst           = 1'b1;
        bus.in_bit    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.sync      = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single frame, 1-cycle latency, counter back at slot 0
        send_frame(16'h9C35, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("t1_latency_valid", 32'(bus.out_valid), 1);
        check("t1_sel_cnt_wrap", 32'(bus.sel_cnt), 0);
        @(posedge clk); #1;
        drain();

        // Held frame stalls only the final beat of the next frame
        bus.out_ready = 1'b0;
        send_frame(16'h9C35, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < M_LAST; k++) drive_beat(1'b1, 1'b0);
`ifdef DEMUX_PARITY_EN
        final_bit = 1'b0;
`else
        final_bit = 1'b1;
`endif
        bus.in_bit   = final_bit;
        bus.in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t2_stall_ready", 32'(bus.in_ready), 0);
            check("t2_hold_valid", 32'(bus.out_valid), 1);
            check("t2_hold_data", 32'({bus.d, bus.c, bus.b, bus.a}), 32'h9C35);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("t2_release_ready", 32'(bus.in_ready), 1);
        model_accept(final_bit, 1'b0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("t2_b2b_valid", 32'(bus.out_valid), 1);
        check("t2_b2b_data", 32'({bus.d, bus.c, bus.b, bus.a}), 32'hFFFF);
        @(posedge clk); #1;
        drain();

        // sync discards a partial frame, alone and together with a beat
        for (int k = 0; k < 7; k++) drive_beat(k[0], 1'b0);
        bus.sync = 1'b1;
        idle(1);
        bus.sync = 1'b0;
        m_cnt    = 0;
        m_bits   = '0;
        send_frame(16'hAAAA, 1'b0, 1'b0, 1'b0);
        drain();
        for (int k = 0; k < 5; k++) drive_beat(1'b1, 1'b0);
        send_frame(16'h0F01, 1'b0, 1'b0, 1'b1);
        drain();

        // Random gaps across three random frames
        for (int f = 0; f < 3; f++) send_frame(16'($urandom), 1'b1, 1'b0, 1'b0);
        drain();

        // Reset mid-frame and while a frame is held
        for (int k = 0; k < 9; k++) drive_beat(1'b1, 1'b0);
        do_reset();
        bus.out_ready = 1'b0;
        send_frame(16'h1234, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("t5_hold_valid", 32'(bus.out_valid), 1);
        @(posedge clk); #1;
        do_reset();
        bus.out_ready = 1'b1;
        send_frame(16'h9C35, 1'b0, 1'b0, 1'b0);
        drain();

        // Parity good and bad on the reference frame
        send_frame(16'h9C35, 1'b0, 1'b0, 1'b0);
        send_frame(16'h9C35, 1'b0, 1'b1, 1'b0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
